// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier feeder and its operand FIFO.
package mult_pkg;

    localparam int DEFAULT_W     = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int COUNT_W       = $clog2(DEFAULT_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        LOAD  = 2'b10,
        BUSY  = 2'b11
    } state_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular-buffer FIFO holding packed {a, b} operand pairs for the multiplier feeder.
module operand_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [2*W-1:0]           push_data,
    input  logic                     pop,
    output logic [2*W-1:0]           pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_feeder.sv
// Sequences queued operand pairs through the Start/Done multiplier, with a watchdog
// and a single-entry valid/ready output register.
module mult_feeder
    import mult_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     mul_start,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    input  logic                     mul_done,
    input  logic [2*W-1:0]           mul_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_data,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          next_state;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2*W-1:0]  fifo_head;
    logic            pop;
    logic            capture;
    logic            abort;
    logic [WDW-1:0]  wd_count;

    assign in_ready  = !fifo_full;
    assign mul_start = (state == START);

    operand_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A launch waits for the output register to drain, so a result is never overwritten.
    // Done is checked before the watchdog so a Done on the final cycle still wins.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START:   next_state = LOAD;
            LOAD:    next_state = BUSY;
            BUSY: begin
                if (mul_done) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (int'(wd_count) >= TIMEOUT - 1) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Watchdog counts from zero in LOAD; at TIMEOUT-1 in BUSY the next edge would reach TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            wd_count  <= '0;
        end else begin
            if (pop) begin
                {mul_a, mul_b} <= fifo_head;
            end
            if (capture) begin
                out_data  <= mul_result;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort) begin
                err <= 1'b1;
            end
            if (state == START) begin
                wd_count <= '0;
            end else if (state == LOAD || state == BUSY) begin
                wd_count <= wd_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_feeder.sv
// Directed bench for mult_feeder: the bench plays both producer/consumer and the multiplier.
module tb_mult_feeder;
    import mult_pkg::*;

    localparam int W       = 16;
    localparam int TIMEOUT = 8;

    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    logic               in_valid   = 1'b0;
    logic [W-1:0]       in_a       = '0;
    logic [W-1:0]       in_b       = '0;
    logic               mul_done   = 1'b0;
    logic [2*W-1:0]     mul_result = '0;
    logic               out_ready  = 1'b0;
    logic               in_ready;
    logic               mul_start;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic               out_valid;
    logic [2*W-1:0]     out_data;
    logic               err;
    logic [COUNT_W-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    mult_feeder #(
        .W       (W),
        .DEPTH   (DEFAULT_DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL push_accept: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!mul_start && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!mul_start) begin
            errors++;
            $display("[TB] FAIL wait_start: mul_start=%b required 1 within 50 cycles", mul_start);
        end
    endtask

    task automatic pulse_done(input logic [2*W-1:0] r);
        mul_done   = 1'b1;
        mul_result = r;
        tick();
        mul_done   = 1'b0;
        mul_result = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_start: got %b required 0", mul_start); end
        checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("[TB] FAIL reset_operands: got %h/%h required 0/0", mul_a, mul_b); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h required 0", out_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b required 0", err); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d required 0", fifo_count); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_pair();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h0012;
        in_b      = 16'h0034;
        tick();
        in_valid  = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d required 1", fifo_count); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_early: got %b required 0", mul_start); end
        tick();
        checks++; if (mul_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %b required 1", mul_start); end
        checks++; if (mul_a !== 16'h0012 || mul_b !== 16'h0034) begin errors++; $display("[TB] FAIL single_operands: got %h/%h required 0012/0034", mul_a, mul_b); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL single_popped: got %0d required 0", fifo_count); end
        tick();
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_width: got %b required 0", mul_start); end
        tick();
        checks++; if (mul_a !== 16'h0012 || mul_b !== 16'h0034) begin errors++; $display("[TB] FAIL single_hold: got %h/%h required 0012/0034", mul_a, mul_b); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_early: got %b required 0", out_valid); end
        pulse_done(32'h000003A8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b required 1", out_valid); end
        checks++; if (out_data !== 32'h000003A8) begin errors++; $display("[TB] FAIL single_data: got %h required 000003a8", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_consume: got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h000003A8) begin errors++; $display("[TB] FAIL single_data_hold: got %h required 000003a8", out_data); end
    endtask

    task automatic test_stray_done();
        pulse_done(32'hDEADBEEF);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h000003A8) begin errors++; $display("[TB] FAIL stray_data: got %h required 000003a8", out_data); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL stray_start: got %b required 0", mul_start); end
    endtask

    task automatic test_fill();
        logic [W-1:0]   fa [5];
        logic [W-1:0]   fb [5];
        logic [2*W-1:0] fp [5];
        fa = '{16'h0011, 16'h0100, 16'hFFFF, 16'h0007, 16'h1234};
        fb = '{16'h0002, 16'h0100, 16'hFFFF, 16'h0009, 16'h0010};
        fp = '{32'h00000022, 32'h00010000, 32'hFFFE0001, 32'h0000003F, 32'h00012340};
        out_ready = 1'b0;
        push_pair(16'h0003, 16'h0005);
        wait_start();
        tick();
        tick();
        pulse_done(32'h0000000F);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000000F) begin errors++; $display("[TB] FAIL fill_stall_result: got %b/%h required 1/0000000f", out_valid, out_data); end
        for (int i = 0; i < 4; i++) push_pair(fa[i], fb[i]);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count4: got %0d required 4", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: in_ready=%b required 0", in_ready); end
        in_valid = 1'b1;
        in_a     = fa[4];
        in_b     = fb[4];
        tick();
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_no_overflow: got %0d required 4", fifo_count); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL fill_blocked_start: got %b required 0", mul_start); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_drain: out_valid/in_ready=%b/%b required 0/0", out_valid, in_ready); end
        tick();
        checks++; if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_pop: count/in_ready=%0d/%b required 3/1", fifo_count, in_ready); end
        checks++; if (mul_start !== 1'b1) begin errors++; $display("[TB] FAIL fill_restart: got %b required 1", mul_start); end
        tick();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_fifth: got %0d required 4", fifo_count); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_start();
                tick();
            end
            checks++; if (mul_a !== fa[i] || mul_b !== fb[i]) begin errors++; $display("[TB] FAIL fill_order_op%0d: got %h/%h required %h/%h", i, mul_a, mul_b, fa[i], fb[i]); end
            tick();
            pulse_done(fp[i]);
            checks++; if (out_valid !== 1'b1 || out_data !== fp[i]) begin errors++; $display("[TB] FAIL fill_order_res%0d: got %b/%h required 1/%h", i, out_valid, out_data, fp[i]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_pair(16'h0002, 16'h0003);
        push_pair(16'h0004, 16'h0005);
        wait_start();
        tick();
        tick();
        pulse_done(32'h00000006);
        for (int i = 0; i < 6; i++) begin
            checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_start cycle %0d: got %b required 0", i, mul_start); end
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000006) begin errors++; $display("[TB] FAIL bp_stable cycle %0d: got %b/%h required 1/00000006", i, out_valid, out_data); end
            tick();
        end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL bp_queued: got %0d required 1", fifo_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_start();
        checks++; if (mul_a !== 16'h0004 || mul_b !== 16'h0005) begin errors++; $display("[TB] FAIL bp_second_ops: got %h/%h required 0004/0005", mul_a, mul_b); end
        tick();
        tick();
        pulse_done(32'h00000014);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000014) begin errors++; $display("[TB] FAIL bp_second_res: got %b/%h required 1/00000014", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        out_ready = 1'b0;
        push_pair(16'h0009, 16'h0009);
        push_pair(16'h000A, 16'h000B);
        wait_start();
        tick();
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wd_early at %0d cycles after LOAD: err=%b required 0", i, err); end
        end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err: got %b required 1", err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wd_no_output: got %b required 0", out_valid); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL wd_idle: mul_start=%b required 0", mul_start); end
        tick();
        checks++; if (mul_start !== 1'b1) begin errors++; $display("[TB] FAIL wd_next_start: got %b required 1", mul_start); end
        checks++; if (mul_a !== 16'h000A || mul_b !== 16'h000B) begin errors++; $display("[TB] FAIL wd_next_ops: got %h/%h required 000a/000b", mul_a, mul_b); end
        tick();
        tick();
        pulse_done(32'h0000006E);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000006E) begin errors++; $display("[TB] FAIL wd_next_res: got %b/%h required 1/0000006e", out_valid, out_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL wd_sticky: got %b required 1", err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        push_pair(16'h0020, 16'h0030);
        push_pair(16'h0040, 16'h0050);
        wait_start();
        tick();
        tick();
        checks++; if (fifo_count !== 3'd1 || mul_a !== 16'h0020) begin errors++; $display("[TB] FAIL rb_setup: count/mul_a=%0d/%h required 1/0020", fifo_count, mul_a); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mul_start !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_outputs: start/valid=%b/%b required 0/0", mul_start, out_valid); end
        checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("[TB] FAIL rb_operands: got %h/%h required 0/0", mul_a, mul_b); end
        checks++; if (out_data !== '0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rb_data_err: got %h/%b required 0/0", out_data, err); end
        checks++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rb_fifo: count/in_ready=%0d/%b required 0/1", fifo_count, in_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (in_ready !== 1'b1 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL rb_release: in_ready/count=%b/%0d required 1/0", in_ready, fifo_count); end
        tick();
        tick();
        checks++; if (mul_start !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rb_idle_after: start/valid=%b/%b required 0/0", mul_start, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_stray_done();
        test_fill();
        test_backpressure();
        test_watchdog();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] aborted");
    end

endmodule

// File: doc/mult_feeder.md
# mult_feeder

Upstream sequencer for the approximate shift-and-multiply unit. Buffers operand pairs from a valid/ready producer in a small FIFO, launches one multiplication at a time with the multiplier's Start pulse protocol, captures the product when the multiplier raises Done, and presents it downstream through a single-entry valid/ready output register. A watchdog aborts a stuck operation and raises a sticky error.

## Interface
- W, 16: operand width; the product is 2W bits.
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- TIMEOUT, 255: maximum cycles from the end of START to mul_done before abort.
- clk  in  1  single clock; all registers rise-edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  producer offers an operand pair.
- in_ready  out  1  FIFO not full.
- in_a, in_b  in  W  operands.
- mul_start  out  1  Start pulse to the multiplier.
- mul_a, mul_b  out  W  operands to the multiplier datapath; held stable from START through BUSY.
- mul_done  in  1  multiplier Done, one cycle wide.
- mul_result  in  2W  multiplier product; valid while mul_done=1.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts.
- out_data  out  2W  product.
- err  out  1  sticky watchdog flag.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: in_ready=1, mul_start=0, mul_a=mul_b=0, out_valid=0, out_data=0, err=0, fifo_count=0, state=IDLE, FIFO pointers=0.
- A FIFO push occurs on each edge where in_valid=1 and in_ready=1. in_ready is !full, computed from the registered count, with no combinational pass-through of pops.
- State machine:
  - IDLE: if the FIFO is non-empty and out_valid=0, pop the head into mul_a/mul_b and go to START.
  - START: mul_start=1 for exactly one cycle, then go to LOAD.
  - LOAD: mul_start=0 for one cycle. The multiplier loads its operands in the cycle after Start falls. Then go to BUSY.
  - BUSY: wait for mul_done. On mul_done=1, register mul_result into out_data, set out_valid=1, and go to IDLE.
- out_valid clears on an edge where out_valid=1 and out_ready=1. out_data holds its value until the next capture.
- Watchdog: a counter clears on entering LOAD and increments each cycle in LOAD and BUSY.
  - If the count reaches TIMEOUT in BUSY without mul_done: set err=1, drop the operand pair, produce no output, and go to IDLE.
  - err clears only on reset.
- mul_done outside BUSY is ignored. mul_done on the same edge the count reaches TIMEOUT counts as a success, and err is not set.
- Operands are passed through unmodified. Width and normalisation are entirely the multiplier's job.

## Timing
- in handshake at edge k with the FIFO previously empty and out_valid=0: IDLE sees the entry in cycle k+1, mul_start=1 in cycle k+2, and LOAD in cycle k+3.
- mul_done=1 in cycle n gives out_valid=1 from cycle n+1.
- Back-to-back operation: the next START requires out_valid=0 as a registered value. A consumer holding out_ready=1 therefore costs one IDLE bubble per result.
- Simultaneous push and pop: both take effect and the count is unchanged. A push while full is impossible because in_ready=0.
- Async reset mid-operation: mul_start and out_valid drop immediately, FIFO contents are discarded, and any in-flight product is lost. After reset release, in_ready=1 on the first cycle.

## Structure
- Package mult_pkg holds:
  - the state enum IDLE/START/LOAD/BUSY, binary encoded;
  - default W and DEPTH constants;
  - a clog2-based count-width constant.
- Sub-module operand_fifo (parameters W, DEPTH):
  - 2W-bit entries, circular buffer with wrap-around pointers and an occupancy count;
  - outputs full and empty;
  - same clk and rst.
- The FSM, watchdog and output register live in mult_feeder.

## Test plan
- Single pair: push a=16'h0012, b=16'h0034. Required: mul_start high exactly one cycle, 2 cycles after the push. mul_a and mul_b hold until Done. Stub returns 32'h000003A8 on mul_done, and out_data=32'h000003A8 with out_valid one cycle later.
- Fill: push 5 pairs with the stub stalled. Required: in_ready=0 after the 4th push with fifo_count=4. The 5th pair is accepted only after the first pop. Products emerge in push order.
- Backpressure: hold out_ready=0 with 2 pairs queued. Required: no second mul_start until the first output handshake. out_data is stable while stalled.
- Watchdog: the stub never asserts Done, with TIMEOUT=8. Required: err=1 exactly 8 cycles after LOAD entry, no out_valid, and the next queued pair starts normally.
- Edge cases:
  - Reset asserted in BUSY: all outputs return to reset values immediately, and fifo_count=0 after release.
  - A stray mul_done in IDLE produces no output.
